// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receiver: FSM states, register offsets
// (selected by addr[3:2]) and STATUS bit positions.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Word offsets as seen on addr[3:2]
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegDiv    = 2'd2;
  localparam logic [1:0] RegIrqEn  = 2'd3;

  localparam int unsigned StatusNotEmpty  = 0;
  localparam int unsigned StatusFull      = 1;
  localparam int unsigned StatusOverrun   = 2;
  localparam int unsigned StatusFrameErr  = 3;
  localparam int unsigned StatusParityErr = 4;
  localparam int unsigned StatusCountLsb  = 8;

  localparam logic [15:0] MinDiv = 16'd4;

  // FIFO occupancy as reported in STATUS[12:8], clipped to its 5-bit field
  function automatic logic [4:0] sat_count(input logic [31:0] count);
    return (count > 32'd31) ? 5'd31 : count[4:0];
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO for the serial receiver. A push into a full FIFO is
// refused unless a pop happens in the same cycle; a pop on empty is ignored.
module rx_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push_i,
  input  logic [7:0]                     wdata_i,
  input  logic                           pop_i,
  output logic [7:0]                     rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(Depth + 1)-1:0]   count_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic [7:0]        mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  // Accept/refuse decisions for this cycle
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CountW'(Depth));
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // Pointer and occupancy state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_q + CountW'(do_push) - CountW'(do_pop);
    end
  end

  // Storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/serial_rx.sv
// Memory-mapped UART receiver (8 data bits, 1 stop bit) with a byte FIFO,
// status flags and a level interrupt. Define UART_RX_PARITY_EN to expect an
// even parity bit between the data bits and the stop bit.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 139,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              push_q, push_d;
  logic              par_bad_q, par_bad_d;
  logic              tick, fe_set, pe_set;

  logic [15:0]       div_q, div_d, div_wr;
  logic [1:0]        irq_en_q, irq_en_d;
  logic              ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
  logic [2:0]        flag_clr;
  logic              valid_q, ready_q, irq_q, irq_d;
  logic [31:0]       rdata_q, rd_val, status_word;
  logic              bus_req, is_wr, pop, ovr_set;
  logic [1:0]        sel;

  logic [7:0]        fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CountW-1:0] fifo_count;

  logic              unused_bits;
  assign unused_bits = ^{wdata[31:16], addr[31:4], addr[1:0]};

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign tick = (cnt_q == 16'd0);

  // Receive FSM next state; div_q is sampled only at reloads
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push_d    = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
    if (state_q != StIdle && !tick) cnt_d = cnt_q - 16'd1;
    case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d   = StStart;
          cnt_d     = div_q >> 1;
          par_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          if (!rx_sync_q) begin
            state_d   = StData;
            cnt_d     = div_q - 16'd1;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          cnt_d     = div_q - 16'd1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          cnt_d   = div_q - 16'd1;
          state_d = StStop;
          if (^{shift_q, rx_sync_q}) begin
            pe_set    = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          if (rx_sync_q) push_d = ~par_bad_q;
          else           fe_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Receive FSM state; a reset drops any frame in progress silently
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      push_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      par_bad_q <= par_bad_d;
    end
  end

  rx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Bus decode, register writes, flag updates and read mux
  always_comb begin
    bus_req  = valid & ~valid_q;
    is_wr    = |wstrb;
    sel      = addr[3:2];
    pop      = bus_req & ~is_wr & (sel == RegData);
    ovr_set  = push_q & fifo_full & ~pop;
    div_d    = div_q;
    irq_en_d = irq_en_q;
    flag_clr = 3'b000;
    div_wr   = {wstrb[1] ? wdata[15:8] : div_q[15:8], wstrb[0] ? wdata[7:0] : div_q[7:0]};
    if (bus_req && is_wr) begin
      unique case (sel)
        RegDiv:    div_d = (div_wr < MinDiv) ? MinDiv : div_wr;
        RegIrqEn:  if (wstrb[0]) irq_en_d = wdata[1:0];
        RegStatus: if (wstrb[0]) flag_clr = wdata[4:2];
        RegData:   ;
      endcase
    end
    // Set wins over a simultaneous clear so no event is lost
    ovr_d = (ovr_q & ~flag_clr[0]) | ovr_set;
    fe_d  = (fe_q  & ~flag_clr[1]) | fe_set;
    pe_d  = (pe_q  & ~flag_clr[2]) | pe_set;
    irq_d = (irq_en_q[0] & ~fifo_empty) | (irq_en_q[1] & (ovr_q | fe_q | pe_q));

    status_word = 32'd0;
    status_word[StatusNotEmpty]  = ~fifo_empty;
    status_word[StatusFull]      = fifo_full;
    status_word[StatusOverrun]   = ovr_q;
    status_word[StatusFrameErr]  = fe_q;
    status_word[StatusParityErr] = pe_q;
    status_word[StatusCountLsb +: 5] = sat_count(32'(fifo_count));

    unique case (sel)
      RegData:   rd_val = {24'd0, fifo_empty ? 8'd0 : fifo_rdata};
      RegStatus: rd_val = status_word;
      RegDiv:    rd_val = {16'd0, div_q};
      RegIrqEn:  rd_val = {30'd0, irq_en_q};
    endcase
  end

  // Register file, one-shot ready and registered read data / interrupt
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q    <= 16'(DEFAULT_DIV);
      irq_en_q <= 2'b00;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      irq_en_q <= irq_en_d;
      ovr_q    <= ovr_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
      valid_q  <= valid;
      ready_q  <= bus_req;
      rdata_q  <= (bus_req && !is_wr) ? rd_val : 32'd0;
      irq_q    <= irq_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 139, reset value of the baud divisor in clk cycles per bit (16 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO depth in bytes; power of two, 2..256.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port resetn, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port valid, input, 1, bus request already qualified by address select.
REQ-006 SHALL have port ready, output, 1, bus completion pulse.
REQ-007 SHALL have port wstrb, input, 4, byte write strobes; all-zero means read.
REQ-008 SHALL have port addr, input, 32, byte address; only addr[3:2] decoded.
REQ-009 SHALL have port wdata, input, 32, write data.
REQ-010 SHALL have port rdata, output, 32, read data; valid while ready=1, 0 otherwise.
REQ-011 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-012 SHALL have port irq, output, 1, level interrupt request to CPU irq vector.

Function
REQ-013 SHALL assert ready for exactly one cycle, the cycle after valid rises; no second ready while valid is held through that cycle.
REQ-014 SHALL map the registers: 0x0 DATA (read pops one byte into rdata[7:0]; write ignored), 0x4 STATUS, 0x8 DIV (bits[15:0], RW), 0xC IRQ_EN (bits[1:0], RW).
REQ-015 SHALL define STATUS bits: 0 not-empty, 1 full, 2 overrun, 3 frame error, 4 parity error, [12:8] FIFO count (saturating at 31); writing 1 to bits 2-4 clears them.
REQ-016 SHALL treat DIV writes below 4 as 4.
REQ-017 SHALL pass rx through a 2-FF synchronizer before any use.
REQ-018 SHALL run the FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-019 SHALL, in IDLE, move to START on a synchronized falling edge and load the bit counter with DIV/2.
REQ-020 SHALL, at the START midpoint, go to DATA if rx is 0, else return to IDLE as a glitch with no flag.
REQ-021 SHALL, in DATA, sample every DIV cycles, 8 bits LSB first.
REQ-022 SHALL, in STOP, sample once: if 1, push the byte the next cycle; if 0, set frame error and discard the byte.
REQ-023 SHALL set overrun and drop the new byte when a push hits a full FIFO; existing contents are kept.
REQ-024 SHALL let a push and a pop in the same cycle both take effect, count unchanged; a pop on an empty FIFO returns 0 and leaves count at 0.
REQ-025 SHALL take a DIV write mid-frame effect at the next bit-interval reload.
REQ-026 SHALL drive irq = (IRQ_EN[0] & not-empty) | (IRQ_EN[1] & (overrun | frame error | parity error)), registered.

Reset
REQ-027 SHALL, with resetn=0 at a clk edge, set: ready=0, rdata=0, irq=0, FSM=IDLE, FIFO empty, all flags 0, DIV=DEFAULT_DIV, IRQ_EN=0, synchronizer flops=1.
REQ-028 SHALL discard a frame in progress when reset is asserted mid-frame, with no flag set.

Configuration
REQ-029 SHALL, when UART_RX_PARITY_EN is defined, add a PARITY state between DATA and STOP expecting even parity, set STATUS bit 4 on mismatch and discard the byte.
REQ-030 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and read STATUS bit 4 as 0.

Structure
REQ-031 SHALL place the FSM state enum, register offsets and STATUS bit positions in package serial_rx_pkg.
REQ-032 SHALL implement the FIFO as sub-module rx_fifo (synchronous, push/pop/full/empty/count).

Verification
REQ-033 SHALL cover: DIV=139, send 0xA5 with 8N1 framing -> STATUS=0x0101, DATA read returns 0x000000A5, STATUS then 0x0000.
REQ-034 SHALL cover: 17 bytes 0x00..0x10 with no reads -> full=1, overrun=1; 16 reads return 0x00..0x0F.
REQ-035 SHALL cover: stop bit driven 0 on 0x55 -> frame error=1, count 0; IRQ_EN=2 gives irq=1; writing 0x8 to STATUS clears it and irq=0.
REQ-036 SHALL cover: a 40-cycle low glitch on rx -> FSM back in IDLE, no byte and no flags.
REQ-037 SHALL cover: resetn pulsed during data bit 4 of 0x3C -> FIFO empty, DIV=139, a following 0x3C is received correctly.
REQ-038 SHALL cover: UART_RX_PARITY_EN with 0x07 sent with parity bit 0 -> STATUS bit 4=1, byte discarded.
